// File: rtl/serial2parallel_if.sv
// Byte-stream in / 65-bit word out handshake bundle for serial2parallel.
interface serial2parallel_if;
   logic        pull_in;
   logic [7:0]  data_i;
   logic        sign_in;
   logic        last_in;
   logic        ready_i;
   logic        clr_err;
   logic [64:0] data_o65;
   logic        valid_o;
   logic        busy;
   logic        frame_err;
   logic        overrun;

   modport master (
      output pull_in, data_i, sign_in, last_in, ready_i, clr_err,
      input  data_o65, valid_o, busy, frame_err, overrun
   );

   modport slave (
      input  pull_in, data_i, sign_in, last_in, ready_i, clr_err,
      output data_o65, valid_o, busy, frame_err, overrun
   );
endinterface

// File: rtl/serial2parallel.sv
// Assembles an 8-byte LSB-first stream plus sign bit into a 65-bit word with a
// single-slot valid/ready output and sticky framing-error detection.
//
// state | meaning
// IDLE  | waiting for pull_in (byte 0)
// RECV  | receiving bytes 1..7, cnt = index of current byte
module serial2parallel (
   input  logic clk,
   input  logic rst_n,
   serial2parallel_if.slave bus
);
   typedef enum logic {IDLE, RECV} state_t;

   state_t      state;
   logic [2:0]  cnt;
   logic [64:0] asm_q;
   logic [64:0] data_q;
   logic        valid_q;
   logic        err_q;
   logic        ovr_q;

   logic [64:0] word_done;
   logic        slot_free;

   // Byte 7 goes straight into the output word; it is never held in asm_q.
   assign word_done = {asm_q[64], bus.data_i, asm_q[55:0]};
   assign slot_free = !valid_q || bus.ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= 3'd0;
         asm_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ovr_q <= 1'b0;
         if (valid_q && bus.ready_i)
            valid_q <= 1'b0;
         // A new error later in this block overrides the clear.
         if (bus.clr_err)
            err_q <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.pull_in) begin
                  asm_q <= {bus.sign_in, 56'd0, bus.data_i};
                  cnt   <= 3'd1;
                  state <= RECV;
               end else if (bus.last_in) begin
                  err_q <= 1'b1;
               end
            end
            RECV: begin
               if (bus.pull_in) begin
                  err_q <= 1'b1;
                  asm_q <= {bus.sign_in, 56'd0, bus.data_i};
                  cnt   <= 3'd1;
               end else if (cnt == 3'd7) begin
                  cnt   <= 3'd0;
                  state <= IDLE;
                  if (bus.last_in) begin
                     if (slot_free) begin
                        data_q  <= word_done;
                        valid_q <= 1'b1;
                     end else begin
                        ovr_q <= 1'b1;
                     end
                  end else begin
                     err_q <= 1'b1;
                  end
               end else if (bus.last_in) begin
                  err_q <= 1'b1;
                  cnt   <= 3'd0;
                  state <= IDLE;
               end else begin
                  asm_q[{cnt, 3'b000} +: 8] <= bus.data_i;
                  cnt <= cnt + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.data_o65  = data_q;
   assign bus.valid_o   = valid_q;
   assign bus.busy      = (state == RECV);
   assign bus.frame_err = err_q;
   assign bus.overrun   = ovr_q;
endmodule
